acq_capture: RTL
================

ACQ_CAPTURE -- requirements
Module: acq_capture

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, giving a sample buffer depth of 2^DEPTH_LOG2 samples.
REQ-002 SHALL have port clk, input, 1, system clock; all logic is on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset; one clock, and reset is synchronous and active-high.
REQ-004 SHALL have port grant_acq, input, 1, level grant from the dispatcher; high means acquisition is allowed.
REQ-005 SHALL have port probe, input, 8, logic analyser probe lines.
REQ-006 SHALL have port trig_mask, input, 8, trigger bit-care mask; a 1 bit is compared.
REQ-007 SHALL have port trig_value, input, 8, required level on the masked bits.
REQ-008 SHALL have port div, input, 8, sample prescaler; one sample every div+1 clocks.
REQ-009 SHALL have port done_acq, output, 1, capture complete; returned to the dispatcher.
REQ-010 SHALL have port armed, output, 1, high while waiting for the trigger (LED drive).
REQ-011 SHALL have port wr_en, output, 1, buffer write strobe.
REQ-012 SHALL have port wr_addr, output, DEPTH_LOG2, buffer write address.
REQ-013 SHALL have port wr_data, output, 8, sample written to the buffer.

Function
REQ-014 SHALL implement the states IDLE, WAIT_TRIG, CAPTURE and DONE.
REQ-015 IDLE->WAIT_TRIG SHALL occur on the first clock where grant_acq=1; the prescaler is cleared to 0 on entry.
REQ-016 SHALL produce a sample tick when the prescaler equals div, then wrap the prescaler to 0; div=0 SHALL give a tick every clock.
REQ-017 In WAIT_TRIG, a tick with (sample & trig_mask)==(trig_value & trig_mask) SHALL write that sample at address 0 and move to CAPTURE; trig_mask=0 SHALL trigger on the first tick.
REQ-018 In CAPTURE, each tick SHALL write the sample at the incremented address; wr_en is high for exactly one clock per tick, and wr_addr/wr_data are valid in that same clock.
REQ-019 The write at address 2^DEPTH_LOG2-1 SHALL move the block to DONE on the next clock; the address SHALL never wrap within one capture.
REQ-020 In DONE, done_acq SHALL be held high until grant_acq=0, then the block SHALL return to IDLE on the following clock.
REQ-021 grant_acq=0 in WAIT_TRIG or CAPTURE SHALL abort to IDLE on the next clock, with no done_acq and no further writes; a write already issued in that clock stands.
REQ-022 armed SHALL be 1 exactly while the state is WAIT_TRIG.
REQ-023 div SHALL be sampled live; a change during capture takes effect from the next prescaler wrap.

Reset
REQ-024 rst=1 SHALL force IDLE, with done_acq, armed, wr_en, wr_addr, wr_data, the prescaler and the synchroniser flops all 0, taking priority over every other input, including mid-capture.

Configuration
REQ-025 With ACQ_SYNC_EN defined, probe SHALL pass through a two-flop synchroniser before trigger compare and storage, adding 2 clocks of sample latency.
REQ-026 Without ACQ_SYNC_EN, probe SHALL be used directly, with 0 added latency.

Structure
REQ-027 Package la_pkg SHALL hold the state enum, SAMPLE_W=8 and the default DEPTH_LOG2.
REQ-028 The tick generator SHALL be a sub-module named acq_prescaler (inputs clk, rst, clr, div; output tick).

Verification
REQ-029 DEPTH_LOG2=4, div=0, mask=0, grant high -> 16 writes at addr 0..15 on consecutive clocks, then done_acq=1 held until grant drops, then IDLE.
REQ-030 div=3, mask=0 -> writes spaced exactly 4 clocks apart.
REQ-031 mask=8'h81, value=8'h81, probe=00,01,80,81 -> armed through the first three ticks; first write at addr 0 with data 8'h81.
REQ-032 grant dropped after write 5 -> no write at addr 6, done_acq stays 0, armed=0, next grant restarts at addr 0.
REQ-033 rst pulsed mid-CAPTURE -> all outputs 0 the next clock; a new capture starts cleanly at addr 0.
REQ-034 ACQ_SYNC_EN defined, probe step 00->FF with mask=FF, value=FF -> trigger write occurs 2 clocks later than in the build without the macro.

Source files
------------

// File: rtl/la_pkg.sv
// rtl/la_pkg.sv - shared types and constants for the logic-analyser capture block
package la_pkg;

  localparam int SAMPLE_W       = 8;
  localparam int DIV_W          = 8;
  localparam int DEPTH_LOG2_DEF = 10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    DONE      = 2'd3
  } acq_state_e;

  // Only bits set in the mask take part in the trigger compare.
  function automatic logic trig_hit(input logic [SAMPLE_W-1:0] smp,
                                    input logic [SAMPLE_W-1:0] mask,
                                    input logic [SAMPLE_W-1:0] value);
    return ((smp & mask) == (value & mask));
  endfunction

endpackage

// File: rtl/acq_capture_if.sv
// rtl/acq_capture_if.sv - dispatcher handshake and sample-buffer write bus
interface acq_capture_if #(
  parameter int DEPTH_LOG2 = la_pkg::DEPTH_LOG2_DEF
) ();

  logic                          grant_acq;
  logic                          done_acq;
  logic                          wr_en;
  logic [DEPTH_LOG2-1:0]         wr_addr;
  logic [la_pkg::SAMPLE_W-1:0]   wr_data;

  modport master (
    input  grant_acq,
    output done_acq,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    output grant_acq,
    input  done_acq,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

endinterface

// File: rtl/acq_prescaler.sv
// rtl/acq_prescaler.sv - sample tick generator, one tick every div+1 clocks
module acq_prescaler
  import la_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] count_q, count_d;
  logic [DIV_W-1:0] div_q, div_d;

  // div is re-sampled at every wrap, so a live change applies to the next period.
  assign tick = !clr && (count_q == div_q);

  always_comb begin
    count_d = count_q + 1'b1;
    div_d   = div_q;
    if (clr || tick) begin
      count_d = '0;
      div_d   = div;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      div_q   <= '0;
    end else begin
      count_q <= count_d;
      div_q   <= div_d;
    end
  end

endmodule

// File: rtl/acq_capture.sv
// rtl/acq_capture.sv - triggered probe capture into a sample buffer; ACQ_SYNC_EN adds a 2-flop probe synchroniser
module acq_capture
  import la_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] probe,
  input  logic [SAMPLE_W-1:0] trig_mask,
  input  logic [SAMPLE_W-1:0] trig_value,
  input  logic [DIV_W-1:0]    div,
  output logic                armed,
  acq_capture_if.master       bus
);

  localparam logic [DEPTH_LOG2-1:0] LAST_ADDR = '1;

  logic [SAMPLE_W-1:0] sample;

`ifdef ACQ_SYNC_EN
  logic [SAMPLE_W-1:0] sync1_q, sync1_d;
  logic [SAMPLE_W-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = probe;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign sample = sync2_q;
`else
  assign sample = probe;
`endif

  acq_state_e            state_q, state_d;
  logic                  done_q, done_d;
  logic                  armed_q, armed_d;
  logic                  wr_en_q, wr_en_d;
  logic [DEPTH_LOG2-1:0] wr_addr_q, wr_addr_d;
  logic [SAMPLE_W-1:0]   wr_data_q, wr_data_d;
  logic                  tick;
  logic                  pre_clr;

  // Prescaler is held at zero outside an active capture so WAIT_TRIG starts from 0.
  assign pre_clr = (state_q == IDLE) || (state_q == DONE);

  acq_prescaler u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr),
    .div  (div),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: begin
        if (bus.grant_acq) state_d = WAIT_TRIG;
      end
      WAIT_TRIG: begin
        if (!bus.grant_acq) begin
          state_d = IDLE;
        end else if (tick && trig_hit(sample, trig_mask, trig_value)) begin
          state_d   = CAPTURE;
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = sample;
        end
      end
      CAPTURE: begin
        // The final write is on the bus this clock; stop before the address can wrap.
        if (!bus.grant_acq) begin
          state_d = IDLE;
        end else if (wr_en_q && (wr_addr_q == LAST_ADDR)) begin
          state_d = DONE;
        end else if (tick) begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_addr_q + 1'b1;
          wr_data_d = sample;
        end
      end
      DONE: begin
        if (!bus.grant_acq) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    armed_d = (state_d == WAIT_TRIG);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      armed_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      armed_q   <= armed_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign armed        = armed_q;
  assign bus.done_acq = done_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;

endmodule
